pong_engine: RTL and testbench

Parametrised Pong game-physics engine. It owns ball position and velocity in sub-pixel fixed point, wall and paddle collisions, scoring, serve/pause control and win detection. It runs on the pixel-domain clock, advances one physics step per `tick` strobe (a divided-clock edge detect, generated outside), and publishes integer ball coordinates and scores to the object renderers, score displays and 7-segment logic.

---
 rtl/pong_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - Pong ball physics, paddle collisions, scoring and serve control
//
// Purpose: owns the ball position/velocity in sub-pixel fixed point, advances one
// physics step per tick strobe, resolves wall and paddle collisions, keeps score
// and detects the winner.
//
// Ports:
//   clk, reset          pixel-domain clock, asynchronous active-high reset
//   tick                one-cycle physics step strobe
//   serve, pause        start/restart request, freeze of PLAY ticks
//   p1_pos, p2_pos      paddle top Y (clamped internally to the playfield)
//   ball_x, ball_y      integer ball coordinates
//   p1_score, p2_score  scores
//   state_o, winner     00 IDLE / 01 PLAY / 10 SCORE / 11 OVER; 01 P1 / 10 P2
//   hit_pulse           [0] P1 paddle hit, [1] P2 paddle hit, one cycle
//   score_pulse         [0] P1 scored, [1] P2 scored, one cycle
module pong_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int SUB_BITS   = 2,
  parameter int BALL_SIZE  = 10,
  parameter int PADDLE_W   = 10,
  parameter int PADDLE_H   = 50,
  parameter int P1_X       = 40,
  parameter int P2_X       = 600,
  parameter int INIT_SPEED = 4,
  parameter int SPEED_STEP = 1,
  parameter int MAX_SPEED  = 24,
  parameter int WIN_SCORE  = 9,
  parameter int AUTO_SERVE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           serve,
  input  logic           pause,
  input  logic [Y_W-1:0] p1_pos,
  input  logic [Y_W-1:0] p2_pos,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic [3:0]     p1_score,
  output logic [3:0]     p2_score,
  output logic [1:0]     state_o,
  output logic [1:0]     winner,
  output logic [1:0]     hit_pulse,
  output logic [1:0]     score_pulse
);

  localparam int PX_W = X_W + SUB_BITS;
  localparam int PY_W = Y_W + SUB_BITS;

  localparam logic [PX_W-1:0] XMAX  = PX_W'((SCREEN_W - BALL_SIZE) << SUB_BITS);
  localparam logic [PY_W-1:0] YMAX  = PY_W'((SCREEN_H - BALL_SIZE) << SUB_BITS);
  localparam logic [PX_W-1:0] X_CEN = PX_W'(((SCREEN_W - BALL_SIZE) / 2) << SUB_BITS);
  localparam logic [PY_W-1:0] Y_CEN = PY_W'(((SCREEN_H - BALL_SIZE) / 2) << SUB_BITS);
  localparam logic [Y_W-1:0]  PAD_MAX = Y_W'(SCREEN_H - PADDLE_H);

  // Collision windows are compared one bit wider so the +size terms cannot wrap.
  localparam logic [X_W:0] P1_LO  = (X_W+1)'(P1_X);
  localparam logic [X_W:0] P1_HI  = (X_W+1)'(P1_X + PADDLE_W);
  localparam logic [X_W:0] P2_LO  = (X_W+1)'(P2_X);
  localparam logic [X_W:0] P2_HI  = (X_W+1)'(P2_X + PADDLE_W);
  localparam logic [X_W:0] BALL_W = (X_W+1)'(BALL_SIZE);
  localparam logic [Y_W:0] BALL_MID = (Y_W+1)'(BALL_SIZE / 2);
  localparam logic [Y_W:0] PAD_LEN  = (Y_W+1)'(PADDLE_H);

  localparam logic [7:0] V_INIT = 8'(INIT_SPEED);
  localparam logic [7:0] V_STEP = 8'(SPEED_STEP);
  localparam logic [7:0] V_MAX  = 8'(MAX_SPEED);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_SCORE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PY_W-1:0]   py_q, py_d;
  logic [7:0]        vx_q, vx_d, vy_q, vy_d;
  logic              dx_q, dx_d, dy_q, dy_d;
  logic [3:0]        p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic [1:0]        winner_q, winner_d;
  logic [1:0]        hit_q, hit_d;
  logic [1:0]        score_pulse_q, score_pulse_d;
  logic              scorer_p2_q, scorer_p2_d;  // 0: P1 scored, 1: P2 scored

  logic [Y_W-1:0]    p1_c, p2_c;
  logic [X_W:0]      bx_l, bx_r;
  logic [Y_W:0]      by_m;
  logic              in_p1, in_p2, hit1, hit2, goal_r, goal_l;
  logic [PX_W:0]     px_sum;
  logic [PY_W:0]     py_sum;
  logic [8:0]        vx_sum, vy_sum;
  logic [7:0]        vx_up, vy_up;
  logic [3:0]        p1_inc, p2_inc, new_score;

  // Collision and limit terms, all from the pre-tick registered state.
  always_comb begin
    p1_c   = (p1_pos > PAD_MAX) ? PAD_MAX : p1_pos;
    p2_c   = (p2_pos > PAD_MAX) ? PAD_MAX : p2_pos;
    bx_l   = {1'b0, px_q[PX_W-1:SUB_BITS]};
    bx_r   = bx_l + BALL_W;
    by_m   = {1'b0, py_q[PY_W-1:SUB_BITS]} + BALL_MID;
    in_p1  = (bx_l >= P1_LO) && (bx_l < P1_HI) &&
             (by_m >= {1'b0, p1_c}) && (by_m < ({1'b0, p1_c} + PAD_LEN));
    in_p2  = (bx_r >= P2_LO) && (bx_r < P2_HI) &&
             (by_m >= {1'b0, p2_c}) && (by_m < ({1'b0, p2_c} + PAD_LEN));
    // Only the paddle the ball is heading towards can register a hit.
    hit1   = !dx_q && in_p1;
    hit2   = dx_q && in_p2;
    px_sum = {1'b0, px_q} + (PX_W+1)'(vx_q);
    py_sum = {1'b0, py_q} + (PY_W+1)'(vy_q);
    goal_r = px_sum >= {1'b0, XMAX};
    goal_l = px_q < PX_W'(vx_q);
    vx_sum = {1'b0, vx_q} + {1'b0, V_STEP};
    vy_sum = {1'b0, vy_q} + {1'b0, V_STEP};
    vx_up  = (vx_sum >= {1'b0, V_MAX}) ? V_MAX : vx_sum[7:0];
    vy_up  = (vy_sum >= {1'b0, V_MAX}) ? V_MAX : vy_sum[7:0];
    p1_inc = p1_score_q + 4'd1;
    p2_inc = p2_score_q + 4'd1;
    new_score = scorer_p2_q ? p2_inc : p1_inc;
  end

  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    py_d          = py_q;
    vx_d          = vx_q;
    vy_d          = vy_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    winner_d      = winner_q;
    scorer_p2_d   = scorer_p2_q;
    hit_d         = 2'b00;
    score_pulse_d = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (serve) state_d = S_PLAY;
      end

      S_PLAY: begin
        if (tick && !pause) begin
          if (hit2 || hit1) begin
            // Reflect in place: px is held so the ball leaves the paddle next tick.
            dx_d  = hit1;
            vx_d  = vx_up;
            vy_d  = vy_up;
            hit_d = {hit2, hit1};
          end else if (dx_q && goal_r) begin
            state_d     = S_SCORE;
            scorer_p2_d = 1'b0;
          end else if (!dx_q && goal_l) begin
            state_d     = S_SCORE;
            scorer_p2_d = 1'b1;
          end else begin
            px_d = dx_q ? px_sum[PX_W-1:0] : (px_q - PX_W'(vx_q));
          end

          // Vertical motion uses the old vy even on a paddle-hit tick.
          if (!dy_q) begin
            if (py_q <= PY_W'(vy_q)) begin
              py_d = '0;
              dy_d = 1'b1;
            end else begin
              py_d = py_q - PY_W'(vy_q);
            end
          end else if (py_sum >= {1'b0, YMAX}) begin
            py_d = YMAX;
            dy_d = 1'b0;
          end else begin
            py_d = py_sum[PY_W-1:0];
          end
        end
      end

      S_SCORE: begin
        score_pulse_d = scorer_p2_q ? 2'b10 : 2'b01;
        if (scorer_p2_q) p2_score_d = p2_inc;
        else             p1_score_d = p1_inc;
        if (new_score == WIN) begin
          state_d  = S_OVER;
          winner_d = scorer_p2_q ? 2'b10 : 2'b01;
        end else begin
          // Next serve heads towards the player who conceded.
          px_d    = X_CEN;
          py_d    = Y_CEN;
          vx_d    = V_INIT;
          vy_d    = V_INIT;
          dx_d    = !scorer_p2_q;
          dy_d    = 1'b0;
          state_d = (AUTO_SERVE != 0) ? S_PLAY : S_IDLE;
        end
      end

      S_OVER: begin
        if (serve) begin
          p1_score_d = 4'd0;
          p2_score_d = 4'd0;
          winner_d   = 2'b00;
          px_d       = X_CEN;
          py_d       = Y_CEN;
          vx_d       = V_INIT;
          vy_d       = V_INIT;
          dx_d       = 1'b1;
          dy_d       = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      px_q          <= X_CEN;
      py_q          <= Y_CEN;
      vx_q          <= V_INIT;
      vy_q          <= V_INIT;
      dx_q          <= 1'b1;
      dy_q          <= 1'b0;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      winner_q      <= 2'b00;
      hit_q         <= 2'b00;
      score_pulse_q <= 2'b00;
      scorer_p2_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      py_q          <= py_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      winner_q      <= winner_d;
      hit_q         <= hit_d;
      score_pulse_q <= score_pulse_d;
      scorer_p2_q   <= scorer_p2_d;
    end
  end

  assign ball_x      = px_q[PX_W-1:SUB_BITS];
  assign ball_y      = py_q[PY_W-1:SUB_BITS];
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign state_o     = state_q;
  assign winner      = winner_q;
  assign hit_pulse   = hit_q;
  assign score_pulse = score_pulse_q;

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - self-checking bench for pong_engine
module tb_pong_engine;

  localparam int XMAX = 630 * 4;
  localparam int YMAX = 470 * 4;
  localparam int XCEN = 315 * 4;
  localparam int YCEN = 235 * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, serve = 1'b0, pause = 1'b0;
  logic [9:0]  p1_pos = '0, p2_pos = '0;

  logic [10:0] ball_x, a_ball_x;
  logic [9:0]  ball_y, a_ball_y;
  logic [3:0]  p1_score, p2_score, a_p1_score, a_p2_score;
  logic [1:0]  state_o, winner, hit_pulse, score_pulse;
  logic [1:0]  a_state_o, a_winner, a_hit_pulse, a_score_pulse;
  logic [36:0] obs, a_obs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pong_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .serve(serve), .pause(pause),
    .p1_pos(p1_pos), .p2_pos(p2_pos), .ball_x(ball_x), .ball_y(ball_y),
    .p1_score(p1_score), .p2_score(p2_score), .state_o(state_o), .winner(winner),
    .hit_pulse(hit_pulse), .score_pulse(score_pulse)
  );

  pong_engine #(.AUTO_SERVE(1)) dut_auto (
    .clk(clk), .reset(reset), .tick(tick), .serve(serve), .pause(pause),
    .p1_pos(p1_pos), .p2_pos(p2_pos), .ball_x(a_ball_x), .ball_y(a_ball_y),
    .p1_score(a_p1_score), .p2_score(a_p2_score), .state_o(a_state_o), .winner(a_winner),
    .hit_pulse(a_hit_pulse), .score_pulse(a_score_pulse)
  );

  assign obs   = {ball_x, ball_y, p1_score, p2_score, state_o, winner, hit_pulse, score_pulse};
  assign a_obs = {a_ball_x, a_ball_y, a_p1_score, a_p2_score, a_state_o, a_winner,
                  a_hit_pulse, a_score_pulse};

  // Game-level reference: positions in sub-pixels, state 0 idle/1 play/2 score/3 over,
  // scorer 1 = P1, 2 = P2 (doubles as the winner code).
  typedef struct packed {
    int px; int py; int vx; int vy;
    int dx; int dy; int s1; int s2;
    int st; int win; int hit; int sp; int scorer;
  } mdl_t;

  mdl_t m, ma;

  function automatic mdl_t mreset();
    mdl_t r;
    r = '0;
    r.px = XCEN; r.py = YCEN; r.vx = 4; r.vy = 4; r.dx = 1; r.scorer = 1;
    return r;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic mdl_t mstep(mdl_t c, bit auto_s, bit t, bit s, bit pa, int p1r, int p2r);
    mdl_t n;
    int p1c, p2c, bx, by;
    bit h1, h2;
    n = c;
    n.hit = 0;
    n.sp = 0;
    p1c = imin(p1r, 430);
    p2c = imin(p2r, 430);
    case (c.st)
      0: if (s) n.st = 1;
      1: if (t && !pa) begin
        bx = c.px / 4;
        by = c.py / 4;
        h2 = (c.dx == 1) && bx + 10 >= 600 && bx + 10 < 610 && by + 5 >= p2c && by + 5 < p2c + 50;
        h1 = (c.dx == 0) && bx >= 40 && bx < 50 && by + 5 >= p1c && by + 5 < p1c + 50;
        if (h1 || h2) begin
          n.dx = h1 ? 1 : 0;
          n.vx = imin(c.vx + 1, 24);
          n.vy = imin(c.vy + 1, 24);
          n.hit = h2 ? 2 : 1;
        end else if (c.dx == 1 && c.px + c.vx >= XMAX) begin
          n.st = 2; n.scorer = 1;
        end else if (c.dx == 0 && c.px < c.vx) begin
          n.st = 2; n.scorer = 2;
        end else begin
          n.px = (c.dx == 1) ? c.px + c.vx : c.px - c.vx;
        end
        if (c.dy == 0) begin
          if (c.py <= c.vy) begin n.py = 0; n.dy = 1; end
          else n.py = c.py - c.vy;
        end else begin
          if (c.py + c.vy >= YMAX) begin n.py = YMAX; n.dy = 0; end
          else n.py = c.py + c.vy;
        end
      end
      2: begin
        int ns;
        if (c.scorer == 1) begin n.s1 = c.s1 + 1; ns = n.s1; end
        else begin n.s2 = c.s2 + 1; ns = n.s2; end
        n.sp = c.scorer;
        if (ns == 9) begin
          n.st = 3; n.win = c.scorer;
        end else begin
          n.px = XCEN; n.py = YCEN; n.vx = 4; n.vy = 4; n.dy = 0;
          n.dx = (c.scorer == 1) ? 1 : 0;
          n.st = auto_s ? 1 : 0;
        end
      end
      default: if (s) begin
        n.s1 = 0; n.s2 = 0; n.win = 0;
        n.px = XCEN; n.py = YCEN; n.vx = 4; n.vy = 4; n.dx = 1; n.dy = 0;
        n.st = 0;
      end
    endcase
    return n;
  endfunction

  function automatic logic [36:0] pack(mdl_t c);
    return {11'(c.px / 4), 10'(c.py / 4), 4'(c.s1), 4'(c.s2), 2'(c.st), 2'(c.win),
            2'(c.hit), 2'(c.sp)};
  endfunction

  function automatic logic [9:0] track(mdl_t c);
    int p;
    p = c.py / 4 - 20;
    if (p < 0) p = 0;
    return 10'(p);
  endfunction

  // One clock: inputs applied now, model advanced with what the DUT sampled.
  task automatic cyc(input bit t, input bit s, input bit p);
    tick = t; serve = s; pause = p;
    @(posedge clk);
    m  = mstep(m,  1'b0, t, s, p, int'(p1_pos), int'(p2_pos));
    ma = mstep(ma, 1'b1, t, s, p, int'(p1_pos), int'(p2_pos));
    #1;
  endtask

  task automatic do_reset();
    tick = 0; serve = 0; pause = 0;
    reset = 1'b1;
    m = mreset();
    ma = mreset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== {11'd315, 10'd235, 16'h0}) begin
      n_fail++; $display("FAIL reset_state obs=%h required=%h", obs, {11'd315, 10'd235, 16'h0});
    end
    cyc(0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    #2;
    reset = 1'b1;
    m = mreset();
    ma = mreset();
    #1;
    n_checks++;
    if (obs !== {11'd315, 10'd235, 16'h0} || a_obs !== {11'd315, 10'd235, 16'h0}) begin
      n_fail++; $display("FAIL async_reset obs=%h auto=%h required=%h", obs, a_obs,
                         {11'd315, 10'd235, 16'h0});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_free_flight();
    do_reset();
    p1_pos = 0; p2_pos = 0;
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== 11'd316 || ball_y !== 10'd234) begin
      n_fail++; $display("FAIL first_tick ball=(%0d,%0d) required=(316,234)", ball_x, ball_y);
    end
    for (int i = 2; i <= 235; i++) begin
      cyc(1, 0, 0);
      n_checks++;
      if (obs !== pack(m)) begin
        n_fail++; $display("FAIL flight tick %0d obs=%h expected=%h", i, obs, pack(m));
      end
    end
    n_checks++;
    if (ball_y !== 10'd0) begin
      n_fail++; $display("FAIL top_wall ball_y=%0d required=0", ball_y);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (ball_y !== 10'd1 || ball_x !== 11'd551) begin
      n_fail++; $display("FAIL bounce ball=(%0d,%0d) required=(551,1)", ball_x, ball_y);
    end
  endtask

  task automatic test_p2_hit();
    int hits, g, bx0;
    bit d0;
    do_reset();
    p1_pos = 0; p2_pos = 20;
    cyc(0, 1, 0);
    for (int i = 1; i <= 275; i++) cyc(1, 0, 0);
    cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== 11'd590 || hit_pulse !== 2'b10) begin
      n_fail++; $display("FAIL p2_hit ball_x=%0d hit=%b required 590 10", ball_x, hit_pulse);
    end
    cyc(0, 0, 0);
    n_checks++;
    if (hit_pulse !== 2'b00) begin
      n_fail++; $display("FAIL hit_one_cycle hit=%b required=00", hit_pulse);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== 11'd588 || obs !== pack(m)) begin
      n_fail++; $display("FAIL after_hit ball_x=%0d required=588 obs=%h expected=%h",
                         ball_x, obs, pack(m));
    end
    // Rally with both paddles following the ball until the speed has saturated.
    hits = 1;
    g = 0;
    while (hits < 22 && g < 8000) begin
      p1_pos = track(m); p2_pos = track(m);
      cyc(1, 0, 0);
      if (m.hit != 0) hits++;
      g++;
      n_checks++;
      if (obs !== pack(m)) begin
        n_fail++; $display("FAIL rally cyc %0d obs=%h expected=%h", g, obs, pack(m));
      end
    end
    n_checks++;
    if (g >= 8000) begin
      n_fail++; $display("FAIL rally_timeout hits=%0d required=22", hits);
    end
    g = 0;
    while (!(m.px / 4 >= 200 && m.px / 4 <= 400) && g < 500) begin
      p1_pos = track(m); p2_pos = track(m);
      cyc(1, 0, 0);
      g++;
    end
    bx0 = int'(ball_x);
    d0 = (m.dx == 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    n_checks++;
    if (int'(ball_x) !== (d0 ? bx0 + 24 : bx0 - 24)) begin
      n_fail++; $display("FAIL max_speed ball_x=%0d required=%0d", ball_x, d0 ? bx0 + 24 : bx0 - 24);
    end
  endtask

  task automatic test_goal();
    int g;
    do_reset();
    p1_pos = 0; p2_pos = 400;
    cyc(0, 1, 0);
    g = 0;
    while (m.st != 2 && g < 2000) begin cyc(1, 0, 0); g++; end
    n_checks++;
    if (state_o !== 2'b10 || g >= 2000) begin
      n_fail++; $display("FAIL goal_state state=%b required=10 ticks=%0d", state_o, g);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (obs !== {11'd315, 10'd235, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01}) begin
      n_fail++; $display("FAIL goal_result obs=%h required=%h", obs,
                         {11'd315, 10'd235, 4'd1, 4'd0, 2'b00, 2'b00, 2'b00, 2'b01});
    end
    cyc(0, 1, 0);
    n_checks++;
    if (score_pulse !== 2'b00) begin
      n_fail++; $display("FAIL score_pulse_len pulse=%b required=00", score_pulse);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== 11'd316) begin
      n_fail++; $display("FAIL serve_dir ball_x=%0d required=316", ball_x);
    end
  endtask

  task automatic test_win();
    int g;
    logic [10:0] fx;
    logic [9:0] fy;
    g = 0;
    while (!(m.s1 == 8 && m.st == 2) && g < 6000) begin
      cyc(1, m.st == 0, 0);
      g++;
    end
    cyc(1, 0, 0);
    n_checks++;
    if (state_o !== 2'b11 || winner !== 2'b01 || p1_score !== 4'd9 || g >= 6000) begin
      n_fail++; $display("FAIL win state=%b winner=%b p1=%0d required 11 01 9", state_o, winner, p1_score);
    end
    fx = ball_x; fy = ball_y;
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== fx || ball_y !== fy || state_o !== 2'b11) begin
      n_fail++; $display("FAIL frozen ball=(%0d,%0d) state=%b required=(%0d,%0d) 11",
                         ball_x, ball_y, state_o, fx, fy);
    end
    cyc(0, 1, 0);
    n_checks++;
    if (obs !== {11'd315, 10'd235, 16'h0}) begin
      n_fail++; $display("FAIL restart obs=%h required=%h", obs, {11'd315, 10'd235, 16'h0});
    end
  endtask

  task automatic test_pause();
    logic [36:0] snap;
    do_reset();
    pause = 1;
    cyc(0, 1, 1);
    n_checks++;
    if (state_o !== 2'b01) begin
      n_fail++; $display("FAIL pause_serve state=%b required=01", state_o);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    snap = obs;
    for (int i = 0; i < 10; i++) cyc(1, 0, 1);
    n_checks++;
    if (obs !== snap || obs !== pack(m)) begin
      n_fail++; $display("FAIL paused obs=%h required=%h", obs, snap);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (ball_x !== 11'd319) begin
      n_fail++; $display("FAIL unpause ball_x=%0d required=319", ball_x);
    end
  endtask

  task automatic test_auto_serve();
    int g;
    do_reset();
    p1_pos = 0; p2_pos = 400;
    cyc(0, 1, 0);
    g = 0;
    while (ma.st != 2 && g < 2000) begin cyc(1, 0, 0); g++; end
    cyc(1, 0, 0);
    n_checks++;
    if (a_state_o !== 2'b01 || state_o !== 2'b00 || a_p1_score !== 4'd1 || g >= 2000) begin
      n_fail++; $display("FAIL auto_serve auto_state=%b state=%b score=%0d required 01 00 1",
                         a_state_o, state_o, a_p1_score);
    end
    cyc(1, 0, 0);
    n_checks++;
    if (a_ball_x !== 11'd316 || ball_x !== 11'd315) begin
      n_fail++; $display("FAIL auto_move auto_x=%0d x=%0d required 316 315", a_ball_x, ball_x);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        p1_pos = track(m); p2_pos = track(m);
      end else begin
        p1_pos = 10'($urandom_range(1023, 0));
        p2_pos = 10'($urandom_range(1023, 0));
      end
      cyc($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0);
      n_checks++;
      if (obs !== pack(m) || a_obs !== pack(ma)) begin
        n_fail++; $display("FAIL random cyc %0d obs=%h exp=%h auto=%h exp=%h",
                           i, obs, pack(m), a_obs, pack(ma));
      end
    end
  endtask

  initial begin
    m = mreset();
    ma = mreset();
    test_reset();
    test_free_flight();
    test_p2_hit();
    test_goal();
    test_win();
    test_pause();
    test_auto_serve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
